// File: rtl/poli_pkg.sv
// poli_pkg: shared encodings for the quadratic-polynomial controller and datapath.
package poli_pkg;

  // Controller state encoding; all eight 3-bit codes name a state.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADX = 3'd1,
    S_XX    = 3'd2,
    S_AXX   = 3'd3,
    S_BX    = 3'd4,
    S_ADD1  = 3'd5,
    S_ADDC  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // M0: coefficient mux select
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;
  localparam logic [1:0] SEL_C    = 2'd3;

  // M1: ALU operand-1 select
  localparam logic [1:0] SEL_M0   = 2'd0;
  localparam logic [1:0] SEL_R0   = 2'd1;
  localparam logic [1:0] SEL_R1   = 2'd2;
  localparam logic [1:0] SEL_R2   = 2'd3;

  // M2: ALU operand-2 select (R0 and M0 out swap codes relative to M1)
  localparam logic [1:0] M2_R0    = 2'd0;
  localparam logic [1:0] M2_M0    = 2'd1;
  localparam logic [1:0] M2_R1    = 2'd2;
  localparam logic [1:0] M2_R2    = 2'd3;

  // ALU operation
  localparam logic H_MUL = 1'b1;
  localparam logic H_ADD = 1'b0;

endpackage

// File: rtl/poli_top.sv
// poli_top: bloco_controle wired to a 16-bit datapath (three registers, muxes, one ALU).
module poli_top
  import poli_pkg::*;
#(
  parameter int USE_C = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [15:0] x,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [15:0] r2,
  output logic        pronto,
  output logic        ocupado
);

  logic [1:0]  m0, m1, m2;
  logic        lx, lh, ls, h;
  logic [15:0] r0, r1, m0_out, op1, op2, alu;

  bloco_controle #(.USE_C(USE_C)) u_ctl (
    .clk     (clk),
    .rst     (rst),
    .inicio  (inicio),
    .M0      (m0),
    .M1      (m1),
    .M2      (m2),
    .LX      (lx),
    .LH      (lh),
    .LS      (ls),
    .H       (h),
    .Pronto  (pronto),
    .ocupado (ocupado)
  );

  // Coefficient mux and ALU operand muxes; arithmetic wraps at 16 bits.
  always_comb begin
    m0_out = 16'd0;
    case (m0)
      SEL_A:   m0_out = a;
      SEL_B:   m0_out = b;
      SEL_C:   m0_out = c;
      default: m0_out = 16'd0;
    endcase
    op1 = m0_out;
    case (m1)
      SEL_R0:  op1 = r0;
      SEL_R1:  op1 = r1;
      SEL_R2:  op1 = r2;
      default: op1 = m0_out;
    endcase
    op2 = r0;
    case (m2)
      M2_M0:   op2 = m0_out;
      M2_R1:   op2 = r1;
      M2_R2:   op2 = r2;
      default: op2 = r0;
    endcase
    alu = (h == H_MUL) ? op1 * op2 : op1 + op2;
  end

  // Datapath registers, loaded under controller enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= 16'd0;
      r1 <= 16'd0;
      r2 <= 16'd0;
    end else begin
      if (lx) r0 <= x;
      if (lh) r1 <= alu;
      if (ls) r2 <= alu;
    end
  end

endmodule

// File: rtl/bloco_controle.sv
// bloco_controle: Moore FSM sequencing the datapath through A*x*x + B*x (+ C).
//
// state | meaning
// IDLE  | waiting for inicio
// LOADX | R0 <= x
// XX    | R1 <= x*x
// AXX   | R2 <= A*R1
// BX    | R1 <= B*x
// ADD1  | R2 <= R1 + R2
// ADDC  | R2 <= C + R2 (only when USE_C=1)
// DONE  | result valid, Pronto pulse; inicio restarts directly
module bloco_controle
  import poli_pkg::*;
#(
  parameter int USE_C = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic       Pronto,
  output logic       ocupado
);

  state_t state, state_nx;

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; inicio only matters in IDLE and DONE.
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = inicio ? S_LOADX : S_IDLE;
      S_LOADX: state_nx = S_XX;
      S_XX:    state_nx = S_AXX;
      S_AXX:   state_nx = S_BX;
      S_BX:    state_nx = S_ADD1;
      S_ADD1:  state_nx = (USE_C != 0) ? S_ADDC : S_DONE;
      S_ADDC:  state_nx = S_DONE;
      S_DONE:  state_nx = inicio ? S_LOADX : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode from the state register only.
  always_comb begin
    M0      = SEL_ZERO;
    M1      = SEL_M0;
    M2      = M2_R0;
    LX      = 1'b0;
    LH      = 1'b0;
    LS      = 1'b0;
    H       = H_ADD;
    Pronto  = 1'b0;
    ocupado = (state != S_IDLE);
    case (state)
      S_LOADX: LX = 1'b1;
      S_XX: begin
        M1 = SEL_R0;
        M2 = M2_R0;
        H  = H_MUL;
        LH = 1'b1;
      end
      S_AXX: begin
        M0 = SEL_A;
        M1 = SEL_M0;
        M2 = M2_R1;
        H  = H_MUL;
        LS = 1'b1;
      end
      S_BX: begin
        M0 = SEL_B;
        M1 = SEL_M0;
        M2 = M2_R0;
        H  = H_MUL;
        LH = 1'b1;
      end
      S_ADD1: begin
        M1 = SEL_R1;
        M2 = M2_R2;
        H  = H_ADD;
        LS = 1'b1;
      end
      S_ADDC: begin
        M0 = SEL_C;
        M1 = SEL_M0;
        M2 = M2_R2;
        H  = H_ADD;
        LS = 1'b1;
      end
      S_DONE:  Pronto = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/bloco_controle.md
BLOCO_CONTROLE -- requirements
Module: bloco_controle

Interface
REQ-001 Parameter USE_C, default 1: 1 = add constant C (ADDC step); 0 = skip ADDC.
REQ-002 clk  input  1  single clock; every state change on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 inicio  input  1  start request, sampled on the rising edge.
REQ-005 M0  output  2  datapath coefficient mux select: 0=zero, 1=A, 2=B, 3=C.
REQ-006 M1  output  2  datapath ALU operand-1 select: 0=M0 out, 1=R0, 2=R1, 3=R2.
REQ-007 M2  output  2  datapath ALU operand-2 select: 0=R0, 1=M0 out, 2=R1, 3=R2.
REQ-008 LX  output  1  load enable for R0 (x).
REQ-009 LH  output  1  load enable for R1 (ALU result).
REQ-010 LS  output  1  load enable for R2 (ALU result).
REQ-011 H  output  1  ALU operation: 1=multiply, 0=add.
REQ-012 Pronto  output  1  one-cycle pulse; R2 holds A*x*x + B*x + C (or A*x*x + B*x when USE_C=0).
REQ-013 ocupado  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL be a Moore FSM; all outputs SHALL decode from the state register only.
REQ-015 States and outputs (unlisted outputs = 0):
  - IDLE
  - LOADX: LX=1
  - XX: M1=1, M2=0, H=1, LH=1 (R1 = x*x)
  - AXX: M0=1, M1=0, M2=2, H=1, LS=1 (R2 = A*x*x)
  - BX: M0=2, M1=0, M2=0, H=1, LH=1 (R1 = B*x)
  - ADD1: M1=2, M2=3, H=0, LS=1 (R2 = R1 + R2)
  - ADDC: M0=3, M1=0, M2=3, H=0, LS=1 (R2 = C + R2)
  - DONE: Pronto=1
REQ-016 Transitions SHALL be:
  - IDLE -> LOADX when inicio=1; otherwise stay in IDLE.
  - LOADX -> XX -> AXX -> BX -> ADD1, unconditionally.
  - ADD1 -> ADDC when USE_C=1; ADD1 -> DONE when USE_C=0.
  - ADDC -> DONE.
  - DONE -> LOADX when inicio=1; otherwise DONE -> IDLE.
REQ-017 With USE_C=1, Pronto SHALL be high in the cycle after the 7th rising edge, counting the edge that samples inicio=1 as edge 1; with USE_C=0, after the 6th.
REQ-018 inicio SHALL be ignored in every state except IDLE and DONE; a request made while busy is not queued.
REQ-019 Back-to-back operation: inicio=1 in DONE SHALL start a new evaluation with no IDLE cycle; Pronto stays a single-cycle pulse.
REQ-020 Pronto SHALL never be high for two consecutive cycles.
REQ-021 At most one of LX, LH, LS SHALL be high in any cycle.
REQ-022 ocupado SHALL be 0 in IDLE and 1 in every other state, including DONE.
REQ-023 The datapath arithmetic is 16-bit and wraps modulo 2^16; the controller adds no overflow detection.
REQ-024 Illegal state encodings SHALL go to IDLE on the next edge.

Reset
REQ-025 rst=1 SHALL force state IDLE immediately, without waiting for a clock edge.
REQ-026 During reset, M0=M1=M2=0 and LX=LH=LS=H=Pronto=ocupado=0.
REQ-027 Reset in the middle of a sequence SHALL abort it; no Pronto is produced for the aborted evaluation.
REQ-028 After rst falls, the FSM SHALL stay in IDLE until inicio=1 is sampled.

Structure
REQ-029 A shared package poli_pkg SHALL hold the state encoding constants, the M0/M1/M2 select constants (SEL_ZERO, SEL_A, SEL_B, SEL_C, SEL_R0, SEL_R1, SEL_R2, SEL_M0) and the H_MUL/H_ADD constants.
REQ-030 The block SHALL be a single module with no sub-modules.
REQ-031 A top-level integration module, poli_top, SHALL connect bloco_controle to the datapath.

Verification
REQ-032 Stimulus: reset, then inicio pulse with x=2, A=3, B=2, C=5 (USE_C=1, via poli_top). Required: Pronto 7 cycles after the accepting edge; R2=21.
REQ-033 Stimulus: same operands with USE_C=0. Required: Pronto after 6 cycles; R2=16.
REQ-034 Stimulus: inicio held high continuously. Required: Pronto pulses every 7 cycles; ocupado never drops; no IDLE cycle between evaluations.
REQ-035 Stimulus: rst asserted in BX, between clock edges. Required: outputs go to 0 immediately; no Pronto; a restart with x=3, A=1, B=1, C=1 gives R2=13.
REQ-036 Stimulus: inicio pulses in states XX through ADDC. Required: ignored; exactly one Pronto.
REQ-037 Stimulus: x=256, A=1, B=0, C=0. Required: R2=0 (16-bit wrap); Pronto asserted normally.
